// File: rtl/effect_sample_collector_if.sv
// Sample stream between an effect module, the collector and the codec side.
// Both directions are strobes, with no back-pressure. done qualifies modified_sample
// for one cycle. out_ready asks for one sample. out_valid qualifies out_sample for one cycle.
interface effect_sample_collector_if #(
  parameter int WIDTH = 12
);
  logic             done;
  logic [WIDTH-1:0] modified_sample;
  logic             out_ready;
  logic [WIDTH-1:0] out_sample;
  logic             out_valid;

  modport master (
    output done,
    output modified_sample,
    output out_ready,
    input  out_sample,
    input  out_valid
  );

  modport slave (
    input  done,
    input  modified_sample,
    input  out_ready,
    output out_sample,
    output out_valid
  );
endinterface

// File: rtl/effect_sample_collector.sv
// Effect-stream sink: drops SKIP warm-up samples, buffers the rest in a FIFO
// for the codec side, and meters peak magnitude of every sample offered after warm-up.
module effect_sample_collector #(
  parameter int WIDTH      = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int SKIP       = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  effect_sample_collector_if.slave sif,
  input  logic                  peak_clear,
  input  logic                  flag_clear,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic [WIDTH-2:0]      peak,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] SKIP_LAST = 8'(SKIP - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;
  logic [7:0] skip_cnt, skip_cnt_nxt;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic full, empty, push_req, do_push, do_pop;

  logic [WIDTH-1:0] neg_s;
  logic [WIDTH-2:0] abs_s;

  // ---------------- warm-up FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= WARMUP;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    if (state == WARMUP && sif.done) begin
      skip_cnt_nxt = skip_cnt + 8'd1;
      if (skip_cnt == SKIP_LAST) state_nxt = RUN;
    end
  end

  assign running   = (state == RUN);
  assign state_dbg = state;

  // ---------------- FIFO ----------------
  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  assign push_req = running && sif.done;
  assign do_pop   = sif.out_ready && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push  = push_req && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= sif.modified_sample;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      sif.out_sample <= '0;
      sif.out_valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      sif.out_valid <= sif.out_ready;
      if (sif.out_ready) sif.out_sample <= do_pop ? mem[rd_ptr] : '0;
    end
  end

  // ---------------- peak meter ----------------
  assign neg_s = -sif.modified_sample;

  // The most negative code has no positive twin, so it saturates to all ones.
  always_comb begin
    abs_s = sif.modified_sample[WIDTH-2:0];
    if (sif.modified_sample[WIDTH-1]) begin
      if (neg_s[WIDTH-1]) abs_s = '1;
      else                abs_s = neg_s[WIDTH-2:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      peak <= '0;
    end else if (peak_clear) begin
      peak <= push_req ? abs_s : '0;
    end else if (push_req && (abs_s > peak)) begin
      peak <= abs_s;
    end
  end

  // ---------------- sticky flags ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_req && full && !do_pop) overflow <= 1'b1;
      else if (flag_clear)             overflow <= 1'b0;
      if (sif.out_ready && empty)      underflow <= 1'b1;
      else if (flag_clear)             underflow <= 1'b0;
    end
  end

endmodule

// File: doc/effect_sample_collector.md
Name: effect_sample_collector

Overview:
- Sink end of the effect-module sample interface. Consumes the `modified_sample`/`done` stream from an effects module such as `limiter_module`.
- Discards a fixed warm-up run of samples, then buffers accepted samples in a small FIFO.
- Hands samples to the codec side on that side's own `out_ready` strobe.
- Also tracks a peak-magnitude meter over accepted samples, for the level display.

Parameters:
- WIDTH, 12, sample width in bits (signed two's complement).
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- SKIP, 32, number of initial `done` samples discarded after reset (filter/effect warm-up). Legal range is 1 to 255.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `done`  in  1  one-cycle strobe from the effect module; `modified_sample` is valid in that cycle.
- `modified_sample`  in  WIDTH  signed sample from the effect module.
- `out_ready`  in  1  one-cycle request from the codec side for the next sample.
- `peak_clear`  in  1  synchronous clear of the peak meter.
- `flag_clear`  in  1  synchronous clear of the sticky `overflow` and `underflow` flags.
- `out_sample`  out  WIDTH  signed sample delivered to the codec side (registered).
- `out_valid`  out  1  one-cycle pulse; `out_sample` is updated in this cycle.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy, 0 to 2^DEPTH_LOG2.
- `running`  out  1  high once warm-up has completed.
- `peak`  out  WIDTH-1  largest absolute value accepted since the last clear (unsigned).
- `overflow`  out  1  sticky; a sample was dropped because the FIFO was full.
- `underflow`  out  1  sticky; `out_ready` arrived while the FIFO was empty.

Behaviour:
- Reset values: all outputs 0; FIFO empty; read and write pointers 0; skip counter 0; state WARMUP.
- Reset asserted mid-operation discards all FIFO contents and restarts warm-up.
- **WARMUP state:**
  - Each `done` increments the skip counter; the sample is discarded and not metered.
  - On the `done` where the counter equals SKIP-1, the state goes to RUN.
  - `running` is 1 from the next cycle.
  - The SKIP-th sample is also discarded, so the first sample pushed is sample index SKIP (0-based).
- **RUN state:**
  - Each `done` pushes `modified_sample`.
  - RUN exits only on reset.
- **Push when full, with no pop the same cycle:**
  - The sample is dropped and `overflow` is set.
  - FIFO contents and pointers are unchanged.
- **`out_ready` with the FIFO non-empty:**
  - Pop the head entry.
  - The next cycle shows that sample on `out_sample` with `out_valid`=1 (1-cycle latency).
- **`out_ready` with the FIFO empty:**
  - Next cycle: `out_sample`=0 (silence) with `out_valid`=1.
  - `underflow` is set.
- **Push and pop in the same cycle:**
  - When full: pop succeeds and push succeeds; `level` is unchanged; no overflow.
  - When empty: no bypass. `underflow` is set, output is 0, the sample is stored, and `level` becomes 1.
  - Otherwise `level` is unchanged.
- `level` and the pointers update on the edge following the event.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Full/empty are derived from `level`.
- **Peak meter:**
  - Updates on every pushed sample, including a push that is dropped on overflow.
  - `abs = sample[WIDTH-1] ? -sample : sample`, saturated, so -2048 gives 2047 (WIDTH=12).
  - If `abs` > `peak`, `peak` takes `abs`.
  - `peak_clear` sets `peak` to 0. If `peak_clear` coincides with a push, the result is `peak` = abs of that sample.
- **Sticky flags:**
  - `flag_clear` clears both flags.
  - A set event in the same cycle as `flag_clear` wins, so the flag ends up set.
- Flags and `peak` are held until cleared or reset.

Test Plan:
- Reset, then 40 `done` strobes carrying the values 0..39, no `out_ready` -> `running` rises after the 32nd strobe; `level`=8; `peak`=39.
- After the above, 8 `out_ready` strobes spaced 64 clocks apart -> `out_valid` one cycle after each strobe with `out_sample` = 32..39 in order; `level`=0; `underflow`=0.
- With the FIFO empty in RUN, 1 `out_ready` -> next cycle `out_valid`=1, `out_sample`=0, `underflow`=1. Then `flag_clear` -> `underflow`=0.
- Fill with 16 samples, push a 17th (value 5), no pop -> `overflow`=1, `level`=16, and a full drain returns the original 16 samples. Repeat to full, then push and pop in the same cycle -> `level` stays 16, `overflow` not set.
- In RUN, push -2048, then 100, then `peak_clear` coincident with a push of -7 -> `peak` reads 2047 after the first push and 7 after the clear.
- Assert `reset` asynchronously mid-stream with `level`=5 -> outputs go to 0 immediately, `level`=0, `running`=0; the next 32 `done` strobes are discarded again.
